key_arbiter8: RTL and testbench
===============================

# key_arbiter8

Round-robin arbiter that shares one `mux8_1` tone path among eight key requesters in the digital piano. Each cycle it decides which pressed key owns the shared output, drives the 3-bit mux select and a one-hot grant, and enforces a minimum hold time so short key bounces do not chop the audio. It also enforces a maximum ownership time so that no held key can starve the others.

## Interface
- `N_HOLD`, default 4: minimum cycles a new grant is held regardless of `req`; legal range 1..255.
- `N_MAX`, default 64: ownership cycles after which the owner yields if another key is requesting; must be at least `N_HOLD`; legal range up to 65535.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req` in 8: key request lines; bit k is key k; level-sensitive.
- `sel` out 3: index of the current or most recent winner; drives `mux8_1.sel`.
- `grant` out 8: one-hot of the current owner; all zeros when idle.
- `active` out 1: high while any grant is asserted.
- `switch_pulse` out 1: high for exactly one cycle after each edge where `grant` takes a new non-zero value.

## Operation
- **State:**
  - FSM states: IDLE, HOLD and OWN.
  - `ptr` (3 bits) is the round-robin start point.
  - `hold_cnt` is 8 bits.
  - `own_cnt` is 16 bits and saturates at `N_MAX`.
- **Pick function:** the first set bit of `req` searching `ptr`, `ptr+1`, … with modulo-8 wrap.
- **IDLE:**
  - Outputs: `grant` = 0, `active` = 0, `sel` holds its last value.
  - If `req` is non-zero: grant the pick, load `sel`, set `ptr` to winner+1 mod 8, load `hold_cnt` with `N_HOLD`-1, clear `own_cnt`, and go to HOLD.
- **HOLD:**
  - The grant is frozen; `req[winner]` is ignored.
  - `hold_cnt` decrements and `own_cnt` increments each cycle.
  - When `hold_cnt` is 0, go to OWN on the next edge.
  - With `N_HOLD`=1, HOLD lasts exactly one cycle.
- **OWN, evaluated each cycle in this priority order:**
  - **Owner released and others pending** (`req[winner]`=0, other bits set): switch directly to the pick, with no idle cycle. Reload `hold_cnt`, clear `own_cnt`, go to HOLD.
  - **Owner released and nothing pending:** go to IDLE. `grant` goes to 0 and `sel` is retained.
  - **Owner times out** (`own_cnt` ≥ `N_MAX` and another bit of `req` set): rotate to the pick. The search starts at winner+1, so the owner is last in line. Then go to HOLD.
  - **Otherwise:** keep the grant and increment `own_cnt` (saturating).
- **Edge cases:**
  - Owner releases during HOLD: the grant persists until HOLD ends, then OWN evaluates the release.
  - A key that is released and re-pressed within one cycle while it owns is treated as continuous ownership.
  - `grant` is always one-hot or zero and always equals `1 << sel` when `active`=1.

## Timing
- All outputs are registered.
- **Latency:** `req` sampled at edge t gives `grant`/`sel`/`active` valid after edge t (one cycle).
- **`switch_pulse`:**
  - Asserted in the cycle following the edge that loaded a new owner.
  - This covers IDLE→HOLD, release-switch and timeout rotation.
  - It is not asserted on OWN→IDLE.
- **Reset** (any cycle, including mid-HOLD or mid-OWN): on the next edge, `grant`=0, `sel`=0, `active`=0, `switch_pulse`=0, `ptr`=0, counters=0, state=IDLE. Reset overrides all other conditions.
- **Minimum grant duration:** `N_HOLD` cycles.
- **Maximum wait for a requester:** with all eight requesting continuously, a requester waits no more than 7·(`N_MAX`+1) cycles.

## Test plan
All scenarios use `N_HOLD`=4, `N_MAX`=16 unless noted.
- **Reset/idle:** `reset`=1 for 2 cycles, `req`=0 → `grant`=0, `sel`=0, `active`=0, `switch_pulse`=0 throughout. Then `req`=8'h20 → one cycle later `grant`=8'h20, `sel`=5, `switch_pulse`=1 for one cycle.
- **Hold:** after a grant to key 2, drop `req[2]` on the next cycle → `grant` stays 8'h04 for exactly 4 cycles, then goes to 0 on the following edge.
- **Round-robin and direct switch:** `req`=8'h81 from idle with `ptr`=0 → key 0 wins. Release key 0 after 6 cycles → key 7 is granted on the next edge with no zero-grant cycle. Re-press key 0 while key 7 owns; release key 7 → key 0 is granted.
- **Timeout rotation:** `req`=8'hFF held constant → grant sequence is 0,1,2,…,7,0, each owner holding 17 cycles, with `switch_pulse` at each change.
- **Reset mid-operation:** assert `reset` during HOLD of key 3 → outputs are zero after the next edge. Deassert with `req`=8'h09 → key 0 wins, because `ptr` has returned to 0.
- **Boundary:** with `N_HOLD`=1 and a single-cycle pulse `req`=8'h10 → `grant`=8'h10 for exactly 1 cycle, then idle.

Source files
------------

// File: rtl/key_arbiter8.sv
`default_nettype none
// ============================================================================
// Module   : key_arbiter8
// Brief    : Round-robin arbiter sharing one tone mux among eight key
//            requesters, with minimum hold and maximum ownership times.
// Revision : 1.0  initial release
// ============================================================================
module key_arbiter8 #(
    parameter int N_HOLD = 4,
    parameter int N_MAX  = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    output logic [2:0] sel,
    output logic [7:0] grant,
    output logic       active,
    output logic       switch_pulse
);

    localparam logic [7:0]  c_hold_load = 8'(N_HOLD - 1);
    localparam logic [15:0] c_own_max   = 16'(N_MAX);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_OWN  = 2'd2
    } state_t;

    state_t      r_state;
    logic [2:0]  r_ptr;
    logic [2:0]  r_sel;
    logic [7:0]  r_grant;
    logic [7:0]  r_hold_cnt;
    logic [15:0] r_own_cnt;
    logic        r_active;
    logic        r_switch_pulse;

    logic [2:0]  w_pick;
    logic        w_owner_req;
    logic        w_others;
    logic        w_timeout;
    logic        w_eval;
    logic        w_load;
    logic [15:0] w_own_inc;

    // First set bit of r searching from p upward with wrap; the loop runs
    // from the farthest offset down so the nearest one is assigned last.
    function automatic logic [2:0] pick(input logic [7:0] r, input logic [2:0] p);
        logic [2:0] idx;
        pick = p;
        for (int i = 7; i >= 0; i--) begin
            idx = p + 3'(i);
            if (r[idx]) pick = idx;
        end
    endfunction

    assign w_pick      = pick(req, r_ptr);
    assign w_owner_req = req[r_sel];
    assign w_others    = |(req & ~r_grant);
    assign w_timeout   = (r_own_cnt >= c_own_max);
    assign w_own_inc   = w_timeout ? c_own_max : r_own_cnt + 16'd1;

    // The last HOLD cycle already applies the ownership rules, so a grant
    // lasts exactly N_HOLD cycles when the owner lets go early.
    assign w_eval = (r_state == S_OWN) || ((r_state == S_HOLD) && (r_hold_cnt == 8'd0));

    // r_ptr is always winner+1 once a grant exists, so the same pick serves
    // idle arbitration, release-switch and timeout rotation.
    assign w_load = ((r_state == S_IDLE) && (|req)) ||
                    (w_eval && w_others && (!w_owner_req || w_timeout));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_ptr          <= 3'd0;
            r_sel          <= 3'd0;
            r_grant        <= 8'd0;
            r_hold_cnt     <= 8'd0;
            r_own_cnt      <= 16'd0;
            r_active       <= 1'b0;
            r_switch_pulse <= 1'b0;
        end else begin
            r_switch_pulse <= 1'b0;
            if (w_load) begin
                r_state        <= S_HOLD;
                r_sel          <= w_pick;
                r_grant        <= 8'd1 << w_pick;
                r_ptr          <= w_pick + 3'd1;
                r_hold_cnt     <= c_hold_load;
                r_own_cnt      <= 16'd0;
                r_active       <= 1'b1;
                r_switch_pulse <= 1'b1;
            end else begin
                case (r_state)
                    S_HOLD, S_OWN: begin
                        if (!w_eval) begin
                            r_hold_cnt <= r_hold_cnt - 8'd1;
                            r_own_cnt  <= w_own_inc;
                        end else if (!w_owner_req) begin
                            r_state  <= S_IDLE;
                            r_grant  <= 8'd0;
                            r_active <= 1'b0;
                        end else begin
                            r_state   <= S_OWN;
                            r_own_cnt <= w_own_inc;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign sel          = r_sel;
    assign grant        = r_grant;
    assign active       = r_active;
    assign switch_pulse = r_switch_pulse;

endmodule
`default_nettype wire

// File: tb/tb_key_arbiter8.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_arbiter8
// Brief    : Directed plus randomized bench for key_arbiter8 against an
//            age-based reference model (two parameter sets side by side).
// Revision : 1.0  initial release
// ============================================================================
module tb_key_arbiter8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] req = 8'd0;

    logic [2:0] sel0, sel1;
    logic [7:0] grant0, grant1;
    logic       active0, active1, pulse0, pulse1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    key_arbiter8 #(.N_HOLD(4), .N_MAX(16)) dut0 (
        .clk(clk), .reset(reset), .req(req),
        .sel(sel0), .grant(grant0), .active(active0), .switch_pulse(pulse0)
    );

    key_arbiter8 #(.N_HOLD(1), .N_MAX(4)) dut1 (
        .clk(clk), .reset(reset), .req(req),
        .sel(sel1), .grant(grant1), .active(active1), .switch_pulse(pulse1)
    );

    // Model: owner index (-1 idle), round-robin start, last winner, and the
    // number of edges since the current grant was made.
    typedef struct {
        int owner;
        int ptr;
        int sel;
        int age;
        bit pulse;
    } mdl_t;

    mdl_t m0 = '{-1, 0, 0, 0, 1'b0};
    mdl_t m1 = '{-1, 0, 0, 0, 1'b0};

    function automatic int mpick(input logic [7:0] r, input int start);
        for (int k = 0; k < 8; k++)
            if (r[(start + k) % 8]) return (start + k) % 8;
        return -1;
    endfunction

    function automatic mdl_t give(input mdl_t m, input int w);
        mdl_t n = m;
        n.owner = w; n.sel = w; n.ptr = (w + 1) % 8; n.age = 0; n.pulse = 1'b1;
        return n;
    endfunction

    function automatic mdl_t mstep(input mdl_t m, input logic rst, input logic [7:0] r,
                                   input int nh, input int nm);
        mdl_t n = m;
        bit held, others;
        n.pulse = 1'b0;
        if (rst) return '{-1, 0, 0, 0, 1'b0};
        if (m.owner < 0) begin
            if (r != 8'd0) n = give(m, mpick(r, m.ptr));
        end else if (m.age < nh - 1) begin
            n.age = m.age + 1;
        end else begin
            held   = r[m.owner];
            others = (r & ~(8'd1 << m.owner)) != 8'd0;
            if (others && (!held || m.age >= nm))
                n = give(m, mpick(r, (m.owner + 1) % 8));
            else if (!held)
                n.owner = -1;
            else
                n.age = m.age + 1;
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string pfx, input mdl_t m, input logic [7:0] g,
                             input logic [2:0] s, input logic a, input logic p);
        logic [7:0] eg;
        eg = (m.owner < 0) ? 8'd0 : 8'(1 << m.owner);
        chk({pfx, "_grant"},  16'(g), 16'(eg));
        chk({pfx, "_sel"},    16'(s), 16'(m.sel));
        chk({pfx, "_active"}, 16'(a), 16'(m.owner >= 0));
        chk({pfx, "_pulse"},  16'(p), 16'(m.pulse));
    endtask

    task automatic cyc(input logic rst, input logic [7:0] r);
        @(negedge clk);
        reset = rst;
        req   = r;
        @(posedge clk);
        m0 = mstep(m0, rst, r, 4, 16);
        m1 = mstep(m1, rst, r, 1, 4);
        #1;
        chk_model("d0", m0, grant0, sel0, active0, pulse0);
        chk_model("d1", m1, grant1, sel1, active1, pulse1);
    endtask

    initial begin
        logic [7:0] r;
        logic [7:0] e;

        // Reset and idle
        cyc(1'b1, 8'h00);
        cyc(1'b1, 8'h00);
        chk("rst_grant", 16'(grant0), 16'h0);
        chk("rst_sel",   16'(sel0),   16'h0);
        chk("rst_pulse", 16'(pulse0), 16'h0);
        cyc(1'b0, 8'h00);
        chk("idle_active", 16'(active0), 16'h0);
        cyc(1'b0, 8'h20);
        chk("first_grant", 16'(grant0), 16'h20);
        chk("first_sel",   16'(sel0),   16'h5);
        chk("first_pulse", 16'(pulse0), 16'h1);
        cyc(1'b0, 8'h20);
        chk("pulse_once", 16'(pulse0), 16'h0);
        repeat (6) cyc(1'b0, 8'h00);

        // Minimum hold with early release
        cyc(1'b1, 8'h00);
        cyc(1'b0, 8'h04);
        chk("hold_grant0", 16'(grant0), 16'h04);
        for (int i = 1; i < 4; i++) begin
            cyc(1'b0, 8'h00);
            chk("hold_grant", 16'(grant0), 16'h04);
        end
        cyc(1'b0, 8'h00);
        chk("hold_end", 16'(grant0), 16'h00);

        // Single-cycle hold boundary
        cyc(1'b1, 8'h00);
        cyc(1'b0, 8'h10);
        chk("b1_grant", 16'(grant1), 16'h10);
        cyc(1'b0, 8'h00);
        chk("b1_idle",   16'(grant1), 16'h00);
        chk("b1_selret", 16'(sel1),   16'h4);

        // Round robin and direct switch
        cyc(1'b1, 8'h00);
        cyc(1'b0, 8'h81);
        chk("rr_key0", 16'(grant0), 16'h01);
        repeat (5) cyc(1'b0, 8'h81);
        cyc(1'b0, 8'h80);
        chk("rr_key7",   16'(grant0), 16'h80);
        chk("rr_pulse7", 16'(pulse0), 16'h1);
        repeat (5) cyc(1'b0, 8'h81);
        cyc(1'b0, 8'h01);
        chk("rr_back0", 16'(grant0), 16'h01);

        // Timeout rotation, each owner 17 cycles
        cyc(1'b1, 8'h00);
        cyc(1'b0, 8'hFF);
        chk("to_start", 16'(grant0), 16'h01);
        for (int k = 1; k <= 8; k++) begin
            repeat (16) cyc(1'b0, 8'hFF);
            e = 8'(1 << ((k - 1) % 8));
            chk("to_keep", 16'(grant0), 16'(e));
            cyc(1'b0, 8'hFF);
            e = 8'(1 << (k % 8));
            chk("to_rot",   16'(grant0), 16'(e));
            chk("to_pulse", 16'(pulse0), 16'h1);
        end

        // Reset in the middle of HOLD
        cyc(1'b1, 8'h00);
        cyc(1'b0, 8'h08);
        cyc(1'b0, 8'h08);
        cyc(1'b1, 8'h08);
        chk("mid_rst_grant", 16'(grant0), 16'h00);
        chk("mid_rst_sel",   16'(sel0),   16'h0);
        cyc(1'b0, 8'h09);
        chk("mid_rst_ptr0", 16'(grant0), 16'h01);

        // Randomized traffic against the model
        r = 8'h00;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0)
                r = 8'($urandom);
            else if ($urandom_range(0, 1) == 0)
                r = r ^ 8'(1 << $urandom_range(0, 7));
            if ($urandom_range(0, 19) == 0)
                r = 8'h00;
            cyc($urandom_range(0, 99) == 0, r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
